// File: rtl/dcache_sa.sv
// dcache_sa: set-associative, write-back, write-allocate data cache with true LRU.
// Ports:
//   clk_i, start_i (async active-low reset)
//   proc_read/proc_write/proc_addr/proc_wdata  : pipeline MEM-stage request
//   proc_rdata/proc_stall                      : combinational load data and stall
//   mem_read/mem_write/mem_addr/mem_wdata      : registered line-wide memory request
//   mem_rdata/mem_ready                        : fill data and one-cycle completion pulse
module dcache_sa #(
    parameter int ADDR_W = 32,
    parameter int WORDS  = 8,
    parameter int SETS   = 4,
    parameter int WAYS   = 2,
    localparam int OFF_W  = $clog2(WORDS) + 2,
    localparam int IDX_W  = $clog2(SETS),
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W,
    localparam int LINE_W = 32 * WORDS
) (
    input  logic                    clk_i,
    input  logic                    start_i,
    input  logic                    proc_read,
    input  logic                    proc_write,
    input  logic [ADDR_W-1:0]       proc_addr,
    input  logic [31:0]             proc_wdata,
    output logic [31:0]             proc_rdata,
    output logic                    proc_stall,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [ADDR_W-OFF_W-1:0] mem_addr,
    output logic [LINE_W-1:0]       mem_wdata,
    input  logic [LINE_W-1:0]       mem_rdata,
    input  logic                    mem_ready
);
    localparam int SEL_W  = $clog2(WORDS);
    localparam int IDX_WI = (IDX_W > 0) ? IDX_W : 1;
    localparam int LA_W   = ADDR_W - OFF_W;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int AGE_W  = WAY_W;

    typedef enum logic [1:0] {
        ST_COMPARE   = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2
    } state_t;

    state_t r_state, w_state_nxt;

    logic              r_valid [SETS][WAYS];
    logic              r_dirty [SETS][WAYS];
    logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
    logic [AGE_W-1:0]  r_age   [SETS][WAYS];
    logic [LINE_W-1:0] r_data  [SETS][WAYS];
    logic [WAY_W-1:0]  r_vic;

    logic [SEL_W-1:0]  w_sel;
    logic [IDX_WI-1:0] w_idx;
    logic [TAG_W-1:0]  w_tag;
    logic [LA_W-1:0]   w_line_addr, w_wb_addr;
    logic              w_req, w_hit, w_hit_upd, w_fill, w_vic_dirty, w_inv_found;
    logic [WAYS-1:0]   w_match;
    logic [WAY_W-1:0]  w_hit_way, w_vic, w_inv_way, w_old_way;
    logic [AGE_W-1:0]  w_old_age;
    logic [LINE_W-1:0] w_hit_line;
    logic              w_unused_lsb;

    // Address split; byte-lane bits are not used (word-granular stores only).
    assign w_sel        = proc_addr[OFF_W-1:2];
    assign w_tag        = proc_addr[ADDR_W-1:OFF_W+IDX_W];
    assign w_line_addr  = proc_addr[ADDR_W-1:OFF_W];
    assign w_unused_lsb = ^proc_addr[1:0];

    generate
        if (SETS > 1) begin : g_idx
            assign w_idx = proc_addr[OFF_W +: IDX_WI];
        end else begin : g_noidx
            assign w_idx = {IDX_WI{1'b0}};
        end
    endgenerate

    // Tag compare across all ways of the addressed set.
    always_comb begin
        w_match   = {WAYS{1'b0}};
        w_hit_way = {WAY_W{1'b0}};
        for (int w = 0; w < WAYS; w++) begin
            w_match[w] = r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag);
            if (w_match[w]) w_hit_way = WAY_W'(w);
            else            w_hit_way = w_hit_way;
        end
    end

    // Victim choice: lowest-index invalid way wins over the oldest way.
    always_comb begin
        w_inv_found = 1'b0;
        w_inv_way   = {WAY_W{1'b0}};
        w_old_way   = {WAY_W{1'b0}};
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_idx][w]) begin
                w_inv_found = 1'b1;
                w_inv_way   = WAY_W'(w);
            end else begin
                w_inv_found = w_inv_found;
            end
            if (r_age[w_idx][w] == AGE_W'(WAYS - 1)) w_old_way = WAY_W'(w);
            else                                     w_old_way = w_old_way;
        end
        w_vic = w_inv_found ? w_inv_way : w_old_way;
    end

    assign w_req       = proc_read | proc_write;
    assign w_hit       = |w_match;
    assign w_hit_upd   = (r_state == ST_COMPARE) && w_req && w_hit;
    assign w_fill      = (r_state == ST_ALLOCATE) && mem_ready;
    assign w_vic_dirty = r_valid[w_idx][w_vic] && r_dirty[w_idx][w_vic];
    assign w_wb_addr   = (LA_W'(r_tag[w_idx][w_vic]) << IDX_W) | LA_W'(w_idx);
    assign w_old_age   = r_age[w_idx][w_hit_way];
    assign w_hit_line  = r_data[w_idx][w_hit_way];

    // Load data shows the pre-store word even when a store is also requested.
    assign proc_rdata = ((r_state == ST_COMPARE) && w_hit) ? w_hit_line[{w_sel, 5'd0} +: 32] : 32'd0;
    assign proc_stall = (r_state != ST_COMPARE) || (w_req && !w_hit);

    // Next-state logic for the miss-service sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_COMPARE: begin
                if (w_req && !w_hit) w_state_nxt = w_vic_dirty ? ST_WRITEBACK : ST_ALLOCATE;
                else                 w_state_nxt = ST_COMPARE;
            end
            ST_WRITEBACK: begin
                if (mem_ready) w_state_nxt = ST_ALLOCATE;
                else           w_state_nxt = ST_WRITEBACK;
            end
            ST_ALLOCATE: begin
                if (mem_ready) w_state_nxt = ST_COMPARE;
                else           w_state_nxt = ST_ALLOCATE;
            end
            default: w_state_nxt = ST_COMPARE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) r_state <= ST_COMPARE;
        else          r_state <= w_state_nxt;
    end

    // Registered memory-port requests and the latched victim way.
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= {LA_W{1'b0}};
            mem_wdata <= {LINE_W{1'b0}};
            r_vic     <= {WAY_W{1'b0}};
        end else begin
            case (r_state)
                ST_COMPARE: begin
                    if (w_req && !w_hit) begin
                        r_vic <= w_vic;
                        if (w_vic_dirty) begin
                            mem_write <= 1'b1;
                            mem_addr  <= w_wb_addr;
                            mem_wdata <= r_data[w_idx][w_vic];
                        end else begin
                            mem_read <= 1'b1;
                            mem_addr <= w_line_addr;
                        end
                    end
                end
                ST_WRITEBACK: begin
                    if (mem_ready) begin
                        mem_write <= 1'b0;
                        mem_read  <= 1'b1;
                        mem_addr  <= w_line_addr;
                    end
                end
                ST_ALLOCATE: begin
                    if (mem_ready) mem_read <= 1'b0;
                end
                default: begin
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                end
            endcase
        end
    end

    // Line metadata: valid/dirty/tag and per-set LRU ages.
    always_ff @(posedge clk_i or negedge start_i) begin
        if (!start_i) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    r_valid[s][w] <= 1'b0;
                    r_dirty[s][w] <= 1'b0;
                    r_tag[s][w]   <= {TAG_W{1'b0}};
                    r_age[s][w]   <= AGE_W'(w);
                end
            end
        end else begin
            if (w_hit_upd) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (WAY_W'(w) == w_hit_way)             r_age[w_idx][w] <= {AGE_W{1'b0}};
                    else if (r_age[w_idx][w] < w_old_age)   r_age[w_idx][w] <= r_age[w_idx][w] + AGE_W'(1);
                end
                if (proc_write) r_dirty[w_idx][w_hit_way] <= 1'b1;
            end
            if (w_fill) begin
                r_valid[w_idx][r_vic] <= 1'b1;
                r_dirty[w_idx][r_vic] <= 1'b0;
                r_tag[w_idx][r_vic]   <= w_tag;
            end
        end
    end

    // Line data: whole-line fill or single-word store; validity is tracked separately.
    always_ff @(posedge clk_i) begin
        if (w_fill)                       r_data[w_idx][r_vic] <= mem_rdata;
        else if (w_hit_upd && proc_write) r_data[w_idx][w_hit_way][{w_sel, 5'd0} +: 32] <= proc_wdata;
    end
endmodule

// File: tb/tb_dcache_sa.sv
module tb_dcache_sa;
    localparam int SETS = 4, WAYS = 2, WORDS = 8, OFF_W = 5, LA_W = 27, LINE_W = 256, K = 3;

    logic              clk = 1'b0, start_i = 1'b0;
    logic              proc_read = 1'b0, proc_write = 1'b0;
    logic [31:0]       proc_addr = 32'd0, proc_wdata = 32'd0, proc_rdata;
    logic              proc_stall, mem_read, mem_write, mem_ready = 1'b0;
    logic [LA_W-1:0]   mem_addr;
    logic [LINE_W-1:0] mem_wdata, mem_rdata = {LINE_W{1'b0}};

    dcache_sa dut (
        .clk_i(clk), .start_i(start_i), .proc_read(proc_read), .proc_write(proc_write),
        .proc_addr(proc_addr), .proc_wdata(proc_wdata), .proc_rdata(proc_rdata),
        .proc_stall(proc_stall), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;

    // Backing memory (what the external memory holds) and reference memory (what the processor should see).
    logic [31:0] back_mem [int];
    logic [31:0] ref_mem  [int];
    int          lru_q [SETS][$];   // per set, line addresses, most recent first
    bit          dirty_ln [int];

    int mem_cnt = 0, n_wb = 0, n_fill = 0, n_both = 0, wb_addr = -1, fill_addr = -1;
    logic [LINE_W-1:0] wb_data;

    function automatic logic [31:0] init_word(input int a);
        return (32'(a) * 32'h9E3779B1) ^ 32'hA5A50000;
    endfunction

    function automatic logic [31:0] back_get(input int a);
        if (back_mem.exists(a)) return back_mem[a];
        return init_word(a);
    endfunction

    function automatic logic [31:0] ref_get(input int a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    // External memory: answers each request with mem_ready K cycles after it rises.
    always @(negedge clk) begin
        if (mem_read && mem_write) n_both++;
        if (!start_i) begin
            mem_cnt = 0; mem_ready = 1'b0;
        end else if (mem_read || mem_write) begin
            if (mem_cnt == K) begin
                mem_ready = 1'b1; mem_cnt = 0;
                if (mem_write) begin
                    n_wb++; wb_addr = int'(mem_addr); wb_data = mem_wdata;
                    for (int w = 0; w < WORDS; w++) back_mem[int'(mem_addr) * WORDS + w] = mem_wdata[w*32 +: 32];
                end else begin
                    n_fill++; fill_addr = int'(mem_addr);
                    for (int w = 0; w < WORDS; w++) mem_rdata[w*32 +: 32] = back_get(int'(mem_addr) * WORDS + w);
                end
            end else begin
                mem_ready = 1'b0; mem_cnt++;
            end
        end else begin
            mem_ready = 1'b0; mem_cnt = 0;
        end
    end

    int e_stall, e_nwb, e_wb, e_nfill, e_fill;
    logic [31:0] e_rdata;
    int o_stall;
    logic [31:0] o_rdata;

    // Reference: flat memory plus recency-ordered line lists per set.
    task automatic ref_step(input logic [31:0] addr, input bit wr, input logic [31:0] data);
        int line = int'(addr >> OFF_W);
        int widx = int'(addr >> 2);
        int s = line % SETS;
        int pos = -1;
        e_rdata = ref_get(widx);
        for (int i = 0; i < lru_q[s].size(); i++) if (lru_q[s][i] == line) pos = i;
        e_nwb = 0; e_wb = -1; e_nfill = 0; e_fill = -1;
        if (pos >= 0) begin
            e_stall = 0;
            lru_q[s].delete(pos);
        end else begin
            e_nfill = 1; e_fill = line; e_stall = K + 2;
            if (lru_q[s].size() == WAYS) begin
                int ev = lru_q[s].pop_back();
                if (dirty_ln.exists(ev) && dirty_ln[ev]) begin
                    e_nwb = 1; e_wb = ev; e_stall = 2 * K + 3;
                end
                dirty_ln[ev] = 1'b0;
            end
            dirty_ln[line] = 1'b0;
        end
        lru_q[s].push_front(line);
        if (wr) begin
            dirty_ln[line] = 1'b1;
            ref_mem[widx] = data;
        end
    endtask

    // Drives one request at posedge+1 and holds it until the stall drops (bounded).
    task automatic do_access(input logic [31:0] addr, input bit rd, input bit wr, input logic [31:0] data);
        n_wb = 0; n_fill = 0; wb_addr = -1; fill_addr = -1;
        proc_addr = addr; proc_read = rd; proc_write = wr; proc_wdata = data;
        o_stall = 0; o_rdata = 32'hx;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (!proc_stall) begin
                o_rdata = proc_rdata;
                break;
            end
            o_stall++;
        end
        @(posedge clk); #1;
        proc_read = 1'b0; proc_write = 1'b0;
    endtask

    task automatic test_reset();
        start_i = 1'b0;
        #12;
        n_vec++; if (mem_read !== 1'b0) begin n_err++; $display("FAIL reset_mem_read got=%b want=0", mem_read); end
        n_vec++; if (mem_write !== 1'b0) begin n_err++; $display("FAIL reset_mem_write got=%b want=0", mem_write); end
        n_vec++; if (mem_addr !== '0) begin n_err++; $display("FAIL reset_mem_addr got=%h want=0", mem_addr); end
        n_vec++; if (mem_wdata !== '0) begin n_err++; $display("FAIL reset_mem_wdata got=%h want=0", mem_wdata); end
        n_vec++; if (proc_rdata !== 32'd0) begin n_err++; $display("FAIL reset_proc_rdata got=%h want=0", proc_rdata); end
        @(negedge clk); start_i = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_cold_load();
        ref_step(32'h84, 1'b0, 32'd0);
        do_access(32'h84, 1'b1, 1'b0, 32'd0);
        n_vec++; if (o_stall !== 5) begin n_err++; $display("FAIL cold_stall got=%0d want=5", o_stall); end
        n_vec++; if (n_fill !== 1 || fill_addr !== 4) begin n_err++; $display("FAIL cold_fill got=%0d@%0d want=1@4", n_fill, fill_addr); end
        n_vec++; if (n_wb !== 0) begin n_err++; $display("FAIL cold_nowb got=%0d want=0", n_wb); end
        n_vec++; if (o_rdata !== e_rdata) begin n_err++; $display("FAIL cold_rdata got=%h want=%h", o_rdata, e_rdata); end
        ref_step(32'h84, 1'b0, 32'd0);
        do_access(32'h84, 1'b1, 1'b0, 32'd0);
        n_vec++; if (o_stall !== 0 || n_fill !== 0) begin n_err++; $display("FAIL repeat_hit got=stall%0d/fill%0d want=0/0", o_stall, n_fill); end
        n_vec++; if (o_rdata !== e_rdata) begin n_err++; $display("FAIL repeat_rdata got=%h want=%h", o_rdata, e_rdata); end
    endtask

    task automatic test_store_hit();
        ref_step(32'h84, 1'b1, 32'hDEADBEEF);
        do_access(32'h84, 1'b0, 1'b1, 32'hDEADBEEF);
        n_vec++; if (o_stall !== 0 || n_fill !== 0 || n_wb !== 0) begin n_err++; $display("FAIL store_hit got=stall%0d fill%0d wb%0d want=0", o_stall, n_fill, n_wb); end
        ref_step(32'h84, 1'b0, 32'd0);
        do_access(32'h84, 1'b1, 1'b0, 32'd0);
        n_vec++; if (o_rdata !== 32'hDEADBEEF) begin n_err++; $display("FAIL store_readback got=%h want=deadbeef", o_rdata); end
        n_vec++; if (o_stall !== 0 || n_fill !== 0) begin n_err++; $display("FAIL store_readback_traffic got=stall%0d fill%0d want=0", o_stall, n_fill); end
    endtask

    task automatic test_conflict_wb();
        ref_step(32'h80, 1'b0, 32'd0);  do_access(32'h80, 1'b1, 1'b0, 32'd0);
        n_vec++; if (o_stall !== e_stall) begin n_err++; $display("FAIL conf_0x80 got=%0d want=%0d", o_stall, e_stall); end
        ref_step(32'h100, 1'b0, 32'd0); do_access(32'h100, 1'b1, 1'b0, 32'd0);
        n_vec++; if (o_stall !== 5 || fill_addr !== 8) begin n_err++; $display("FAIL conf_0x100 got=%0d@%0d want=5@8", o_stall, fill_addr); end
        ref_step(32'h180, 1'b0, 32'd0); do_access(32'h180, 1'b1, 1'b0, 32'd0);
        n_vec++; if (n_wb !== 1 || wb_addr !== 4) begin n_err++; $display("FAIL conf_wb got=%0d@%0d want=1@4", n_wb, wb_addr); end
        n_vec++; if (wb_data[63:32] !== 32'hDEADBEEF) begin n_err++; $display("FAIL conf_wb_data got=%h want=deadbeef", wb_data[63:32]); end
        n_vec++; if (n_fill !== 1 || fill_addr !== 12) begin n_err++; $display("FAIL conf_fill got=%0d@%0d want=1@12", n_fill, fill_addr); end
        n_vec++; if (o_stall !== e_stall || o_rdata !== e_rdata) begin n_err++; $display("FAIL conf_load got=%0d/%h want=%0d/%h", o_stall, o_rdata, e_stall, e_rdata); end
    endtask

    task automatic test_lru();
        logic [31:0] seq [4] = '{32'h80, 32'h100, 32'h80, 32'h180};
        for (int i = 0; i < 4; i++) begin
            ref_step(seq[i], 1'b0, 32'd0); do_access(seq[i], 1'b1, 1'b0, 32'd0);
            n_vec++; if (o_stall !== e_stall || o_rdata !== e_rdata || n_wb !== e_nwb) begin n_err++; $display("FAIL lru_step%0d got=%0d/%h/%0d want=%0d/%h/%0d", i, o_stall, o_rdata, n_wb, e_stall, e_rdata, e_nwb); end
        end
        ref_step(32'h80, 1'b0, 32'd0); do_access(32'h80, 1'b1, 1'b0, 32'd0);
        n_vec++; if (o_stall !== 0 || o_rdata !== e_rdata) begin n_err++; $display("FAIL lru_keep_0x80 got=%0d/%h want=0/%h", o_stall, o_rdata, e_rdata); end
    endtask

    task automatic test_reset_mid_alloc();
        bit seen = 1'b0;
        proc_addr = 32'h200; proc_read = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (mem_read) begin seen = 1'b1; break; end
        end
        n_vec++; if (seen !== 1'b1) begin n_err++; $display("FAIL midrst_fill_start got=%b want=1", seen); end
        @(negedge clk); #2;
        start_i = 1'b0; #1;
        n_vec++; if (mem_read !== 1'b0) begin n_err++; $display("FAIL midrst_mem_read got=%b want=0", mem_read); end
        proc_read = 1'b0;
        for (int s = 0; s < SETS; s++) lru_q[s].delete();
        dirty_ln.delete();
        ref_mem = back_mem;
        @(negedge clk); start_i = 1'b1;
        @(posedge clk); #1;
        ref_step(32'h200, 1'b0, 32'd0); do_access(32'h200, 1'b1, 1'b0, 32'd0);
        n_vec++; if (o_stall !== 5 || fill_addr !== 16) begin n_err++; $display("FAIL midrst_remiss got=%0d@%0d want=5@16", o_stall, fill_addr); end
        n_vec++; if (o_rdata !== e_rdata) begin n_err++; $display("FAIL midrst_rdata got=%h want=%h", o_rdata, e_rdata); end
    endtask

    task automatic test_back_to_back();
        ref_step(32'h84, 1'b0, 32'd0); do_access(32'h84, 1'b1, 1'b0, 32'd0);
        ref_step(32'hA4, 1'b0, 32'd0); do_access(32'hA4, 1'b1, 1'b0, 32'd0);
        n_vec++; if (o_rdata !== e_rdata) begin n_err++; $display("FAIL b2b_preload got=%h want=%h", o_rdata, e_rdata); end
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a = ((i % 2 == 0) ? 32'h80 : 32'hA0) + 32'($urandom_range(0, 7) * 4);
            bit wr = 1'($urandom_range(0, 1));
            logic [31:0] d = $urandom;
            ref_step(a, wr, d); do_access(a, !wr, wr, d);
            n_vec++; if (o_stall !== 0) begin n_err++; $display("FAIL b2b_stall%0d got=%0d want=0", i, o_stall); end
            if (!wr) begin
                n_vec++; if (o_rdata !== e_rdata) begin n_err++; $display("FAIL b2b_rdata%0d got=%h want=%h", i, o_rdata, e_rdata); end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 250; i++) begin
            logic [31:0] a = 32'($urandom_range(0, 23) * 32 + $urandom_range(0, 7) * 4);
            int op = $urandom_range(0, 2);
            logic [31:0] d = $urandom;
            bit rd = (op != 1), wr = (op != 0);
            ref_step(a, wr, d); do_access(a, rd, wr, d);
            n_vec++; if (o_stall !== e_stall) begin n_err++; $display("FAIL rnd_stall%0d a=%h got=%0d want=%0d", i, a, o_stall, e_stall); end
            n_vec++; if (n_wb !== e_nwb || wb_addr !== e_wb) begin n_err++; $display("FAIL rnd_wb%0d got=%0d@%0d want=%0d@%0d", i, n_wb, wb_addr, e_nwb, e_wb); end
            n_vec++; if (n_fill !== e_nfill || fill_addr !== e_fill) begin n_err++; $display("FAIL rnd_fill%0d got=%0d@%0d want=%0d@%0d", i, n_fill, fill_addr, e_nfill, e_fill); end
            if (rd) begin
                n_vec++; if (o_rdata !== e_rdata) begin n_err++; $display("FAIL rnd_rdata%0d a=%h got=%h want=%h", i, a, o_rdata, e_rdata); end
            end
        end
        n_vec++; if (n_both !== 0) begin n_err++; $display("FAIL read_write_overlap got=%0d want=0", n_both); end
    endtask

    initial begin
        test_reset();
        test_cold_load();
        test_store_hit();
        test_conflict_wb();
        test_lru();
        test_reset_mid_alloc();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/dcache_sa.md
Name: dcache_sa

Overview:
Parametrised, set-associative, write-back, write-allocate data cache. It sits between the RISC pipeline's MEM stage (DDATA_ren/wen/addr/wdata/rdata plus proc_stall) and the line-wide external memory port (MEM_ren/wen/addr/wdata/rdata/ready). It is the successor of the fixed single-configuration data cache: way count, set count and line size are configurable, and victim selection uses true LRU. proc_stall freezes the whole pipeline while a miss is serviced.

Parameters:
ADDR_W, 32, processor byte-address width.
WORDS, 8, 32-bit words per line; power of two, at least 2.
SETS, 4, number of sets; power of two, at least 1.
WAYS, 2, associativity; one of 1, 2 or 4.
Derived values:
- OFF_W = log2(WORDS) + 2.
- IDX_W = log2(SETS).
- TAG_W = ADDR_W - OFF_W - IDX_W.
- LINE_W = 32 * WORDS.

Ports:
clk_i  in  1  clock; all state changes on the rising edge.
start_i  in  1  asynchronous active-low reset (0 = reset, 1 = run).
proc_read  in  1  load request, held while proc_stall=1.
proc_write  in  1  store request, held while proc_stall=1.
proc_addr  in  ADDR_W  byte address; bits [1:0] ignored.
proc_wdata  in  32  store data.
proc_rdata  out  32  load data; combinational, valid when proc_stall=0.
proc_stall  out  1  combinational; 1 = request not yet complete.
mem_read  out  1  line-fill request (registered).
mem_write  out  1  line-writeback request (registered).
mem_addr  out  ADDR_W-OFF_W  line address (registered).
mem_wdata  out  LINE_W  victim line data (registered).
mem_rdata  in  LINE_W  fill data, valid with mem_ready.
mem_ready  in  1  one-cycle completion pulse for the current mem_read or mem_write.

Behaviour:
- Reset (start_i=0, asynchronous):
  - All valid and dirty bits cleared; state = COMPARE.
  - mem_read, mem_write, mem_addr and mem_wdata are all 0.
  - LRU age of way w in every set = w.
  - proc_rdata = 0.
- Reset mid-transaction: the transaction is abandoned immediately and the line being filled stays invalid.
- Address split: offset = [OFF_W-1:0], word select = [OFF_W-1:2], index = next IDX_W bits, tag = remaining TAG_W bits.
- Request = proc_read | proc_write. If both are asserted, the request is treated as a store; proc_rdata then shows the pre-store word.
- Hit: valid & tag match in exactly one way.
- State COMPARE:
  - No request: proc_stall=0; no state change.
  - Hit: proc_stall=0 in the same cycle.
    - Load: proc_rdata = the selected word of the hit way, combinational.
    - Store: the word is written at the clock edge and the dirty bit is set.
    - The LRU state is updated in both cases.
  - Miss: proc_stall=1. Victim = lowest-index invalid way; otherwise the way with age WAYS-1.
    - Victim valid & dirty: at the edge, go to WRITEBACK; mem_write=1, mem_addr={victim tag, index}, mem_wdata=victim line.
    - Otherwise: at the edge, go to ALLOCATE; mem_read=1, mem_addr=proc_addr[ADDR_W-1:OFF_W].
- State WRITEBACK: proc_stall=1; outputs held stable until mem_ready=1. At that edge:
  - mem_write=0, mem_read=1, mem_addr = the requested line; state = ALLOCATE.
- State ALLOCATE: proc_stall=1; mem_read held until mem_ready=1. At that edge:
  - The victim way is written with mem_rdata, valid=1, dirty=0, tag stored.
  - mem_read=0; state = COMPARE.
  - The retried request then hits in the following cycle. A store completes via the normal hit path, which sets dirty.
- mem_ready seen in COMPARE is ignored.
- mem_read and mem_write are never asserted together.
- Miss latency (clean victim, memory pulses mem_ready K cycles after mem_read rises) = K+2 stalled cycles. A dirty victim adds the writeback duration plus 1.
- LRU, per set, log2(WAYS)-bit ages forming a permutation of 0..WAYS-1:
  - The accessed way gets age 0.
  - Ways whose age was below the accessed way's old age increment by 1.
  - Updated on every hit, including the retry hit after a fill.
  - WAYS=1: no LRU storage; the victim is always way 0.
- The word-enable for stores is derived from the word select bits; there are no byte strobes.

Test Plan:
Defaults (OFF_W=5, 4 sets, 2 ways); memory model pulses mem_ready 3 cycles after a request rises.
1. Cold load from 0x0000_0084 → proc_stall high for 5 cycles; mem_read with mem_addr=4; no mem_write; proc_rdata = word 1 of the returned line; a repeat load stalls 0 cycles.
2. Store 0xDEADBEEF to 0x84 (hit) → 0 stall cycles; a following load of 0x84 returns 0xDEADBEEF with no memory traffic.
3. Set-0 conflict: lines 0x80 (dirty) and 0x100 loaded, then a load of 0x180 → mem_write with mem_addr=4 and mem_wdata containing 0xDEADBEEF at bits [63:32]; then mem_read with mem_addr=12.
4. LRU order: load 0x80, 0x100, 0x80 again, then 0x180 → the victim is the 0x100 way; a later load of 0x80 hits.
5. start_i pulsed low during ALLOCATE → mem_read drops asynchronously; a subsequent load of the same address misses again.
6. Back-to-back hits to alternating sets for 8 cycles → proc_stall stays 0 throughout; proc_rdata is correct every cycle.
